cpu_bus_arbiter: RTL and testbench

Two-master to one-slave bus arbiter placed directly downstream of the CPU core. Merges the core's instruction bus (read-only) and data bus (read/write) onto a single system bus. Arbitration is round-robin or fixed data-priority, with an optional slave-timeout watchdog. Ready and read data are routed back only to the granted master.

---
 rtl/cpu_bus_arbiter_if.sv | 40 ++++
 rtl/cpu_bus_arbiter.sv | 97 +++++++++
 tb/tb_cpu_bus_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of the two CPU-side master buses and the single system-bus slave port
// seen by cpu_bus_arbiter; the arbiter uses the slave view, the environment the master view.
interface cpu_bus_arbiter_if;
  logic        i_ibus_request;
  logic        o_ibus_ready;
  logic [31:0] i_ibus_address;
  logic [31:0] o_ibus_rdata;
  logic        i_dbus_rw;
  logic        i_dbus_request;
  logic        o_dbus_ready;
  logic [31:0] i_dbus_address;
  logic [31:0] i_dbus_wdata;
  logic [31:0] o_dbus_rdata;
  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_bus_wdata;
  logic [1:0]  o_grant;
  logic        o_timeout;

  modport slave (
    input  i_ibus_request, i_ibus_address,
    input  i_dbus_rw, i_dbus_request, i_dbus_address, i_dbus_wdata,
    input  i_bus_ready, i_bus_rdata,
    output o_ibus_ready, o_ibus_rdata, o_dbus_ready, o_dbus_rdata,
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    output o_grant, o_timeout
  );

  modport master (
    output i_ibus_request, i_ibus_address,
    output i_dbus_rw, i_dbus_request, i_dbus_address, i_dbus_wdata,
    output i_bus_ready, i_bus_rdata,
    input  o_ibus_ready, o_ibus_rdata, o_dbus_ready, o_dbus_rdata,
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Two-master (ibus read-only, dbus read/write) to one-slave bus arbiter with
// round-robin or dbus-priority arbitration and an optional slave-response watchdog.
module cpu_bus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 0
) (
  input logic              i_clock,
  input logic              i_reset,
  cpu_bus_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             last_dbus;
  logic             grant_dbus;
  logic             pick_dbus;
  logic             gnt_req;
  logic             tmo_hit;
  logic             xfer_rdy;
  logic [31:0]      xfer_rdata;

  assign grant_dbus = bus.o_grant[1];

  // On a tie round-robin hands the bus to the master that did not have it last.
  assign pick_dbus = bus.i_dbus_request &&
                     (!bus.i_ibus_request || (ROUND_ROBIN == 0) || !last_dbus);

  assign gnt_req = grant_dbus ? bus.i_dbus_request : bus.i_ibus_request;
  assign tmo_hit = (TIMEOUT > 0) && (wd_cnt == CNT_LAST) && !bus.i_bus_ready;

  always_comb begin
    xfer_rdy      = 1'b0;
    xfer_rdata    = '0;
    bus.o_timeout = 1'b0;
    if (state == BUSY && gnt_req) begin
      if (bus.i_bus_ready) begin
        xfer_rdy   = 1'b1;
        xfer_rdata = bus.i_bus_rdata;
      end else if (tmo_hit) begin
        xfer_rdy      = 1'b1;
        bus.o_timeout = 1'b1;
      end
    end
  end

  // Ready and read data reach only the granted master; the other sees zeros.
  assign bus.o_ibus_ready = xfer_rdy && !grant_dbus;
  assign bus.o_dbus_ready = xfer_rdy && grant_dbus;
  assign bus.o_ibus_rdata = (xfer_rdy && !grant_dbus) ? xfer_rdata : '0;
  assign bus.o_dbus_rdata = (xfer_rdy && grant_dbus) ? xfer_rdata : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= IDLE;
      wd_cnt            <= '0;
      last_dbus         <= 1'b0;
      bus.o_bus_request <= 1'b0;
      bus.o_bus_rw      <= 1'b0;
      bus.o_bus_address <= '0;
      bus.o_bus_wdata   <= '0;
      bus.o_grant       <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_ibus_request || bus.i_dbus_request) begin
            bus.o_bus_address <= pick_dbus ? bus.i_dbus_address : bus.i_ibus_address;
            bus.o_bus_rw      <= pick_dbus && bus.i_dbus_rw;
            bus.o_bus_wdata   <= pick_dbus ? bus.i_dbus_wdata : '0;
            bus.o_bus_request <= 1'b1;
            bus.o_grant       <= pick_dbus ? 2'b10 : 2'b01;
            last_dbus         <= pick_dbus;
            wd_cnt            <= '0;
            state             <= BUSY;
          end
        end
        BUSY: begin
          // Completion, abort and watchdog expiry all leave through RELEASE.
          if (!gnt_req || bus.i_bus_ready || tmo_hit) begin
            bus.o_bus_request <= 1'b0;
            state             <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          bus.o_grant <= 2'b00;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Random bench for cpu_bus_arbiter: a round-robin/watchdog instance against a
// transaction-level reference model, plus a dbus-priority instance under constant contention.
module tb_cpu_bus_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst_f;
  always #5 clk = ~clk;

  cpu_bus_arbiter_if bus_a();
  cpu_bus_arbiter_if bus_f();

  cpu_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TMO)) dut_a (
    .i_clock(clk), .i_reset(rst), .bus(bus_a)
  );
  cpu_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) dut_f (
    .i_clock(clk), .i_reset(rst_f), .bus(bus_f)
  );

  // Zero-wait slave for the priority instance.
  assign bus_f.i_bus_ready = bus_f.o_bus_request;
  assign bus_f.i_bus_rdata = 32'h0000_0013;

  int n_tests = 0;
  int n_fail  = 0;
  int n_tmo   = 0;
  int n_abort = 0;
  int n_tie_i = 0;
  int n_tie_d = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction in flight, its age in BUSY cycles, and a one-cycle cooldown.
  bit          m_active, m_rel, m_who, m_last;
  int          m_age;
  logic [31:0] m_addr, m_wdata;
  logic        m_rw;

  bit          e_ir, e_dr, e_to, fin, greq;
  logic [31:0] e_ird, e_drd;
  logic [1:0]  e_grant;

  initial begin
    rst   = 1'b1;
    rst_f = 1'b1;
    bus_a.i_ibus_request = 1'b1;
    bus_a.i_ibus_address = 32'h0000_0100;
    bus_a.i_dbus_request = 1'b1;
    bus_a.i_dbus_rw      = 1'b1;
    bus_a.i_dbus_address = 32'h2000_0000;
    bus_a.i_dbus_wdata   = 32'hCAFE_BABE;
    bus_a.i_bus_ready    = 1'b0;
    bus_a.i_bus_rdata    = 32'h0;
    bus_f.i_ibus_request = 1'b1;
    bus_f.i_ibus_address = 32'h0000_0100;
    bus_f.i_dbus_request = 1'b1;
    bus_f.i_dbus_rw      = 1'b1;
    bus_f.i_dbus_address = 32'h2000_0000;
    bus_f.i_dbus_wdata   = 32'hCAFE_BABE;
    m_active = 0; m_rel = 0; m_who = 0; m_last = 0; m_age = 0;
    m_addr = '0; m_wdata = '0; m_rw = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",    bus_a.o_bus_request, 0);
    chk("rst_rw",     bus_a.o_bus_rw, 0);
    chk("rst_addr",   bus_a.o_bus_address, 0);
    chk("rst_wdata",  bus_a.o_bus_wdata, 0);
    chk("rst_iready", bus_a.o_ibus_ready, 0);
    chk("rst_dready", bus_a.o_dbus_ready, 0);
    chk("rst_irdata", bus_a.o_ibus_rdata, 0);
    chk("rst_drdata", bus_a.o_dbus_rdata, 0);
    chk("rst_grant",  bus_a.o_grant, 0);
    chk("rst_tmo",    bus_a.o_timeout, 0);
    chk("rst_f_req",  bus_f.o_bus_request, 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_f = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      e_grant = (m_active || m_rel) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
      greq = m_who ? bus_a.i_dbus_request : bus_a.i_ibus_request;
      e_ir = 0; e_dr = 0; e_to = 0; fin = 0; e_ird = '0; e_drd = '0;
      if (m_active) begin
        if (!greq) begin
          fin = 1;
          n_abort++;
        end else if (bus_a.i_bus_ready) begin
          fin = 1;
          if (m_who) begin e_dr = 1; e_drd = bus_a.i_bus_rdata; end
          else       begin e_ir = 1; e_ird = bus_a.i_bus_rdata; end
        end else if (m_age == TMO - 1) begin
          fin = 1; e_to = 1; n_tmo++;
          if (m_who) e_dr = 1; else e_ir = 1;
        end
      end
      chk("req",    bus_a.o_bus_request, m_active);
      chk("grant",  bus_a.o_grant, e_grant);
      chk("addr",   bus_a.o_bus_address, m_addr);
      chk("rw",     bus_a.o_bus_rw, m_rw);
      chk("wdata",  bus_a.o_bus_wdata, m_wdata);
      chk("iready", bus_a.o_ibus_ready, e_ir);
      chk("dready", bus_a.o_dbus_ready, e_dr);
      chk("irdata", bus_a.o_ibus_rdata, e_ird);
      chk("drdata", bus_a.o_dbus_rdata, e_drd);
      chk("tmo",    bus_a.o_timeout, e_to);
      if (cyc == 1) chk("first_tie", bus_a.o_grant, 2'b10);

      // Priority instance: dbus wins every 3-cycle transaction, ibus starves.
      chk("f_iready", bus_f.o_ibus_ready, 0);
      chk("f_irdata", bus_f.o_ibus_rdata, 0);
      chk("f_dready", bus_f.o_dbus_ready, (cyc % 3) == 1);
      chk("f_drdata", bus_f.o_dbus_rdata, ((cyc % 3) == 1) ? 32'h13 : 32'h0);
      chk("f_grant",  bus_f.o_grant, ((cyc % 3) == 0) ? 2'b00 : 2'b10);
      if (cyc > 0) begin
        chk("f_rw",    bus_f.o_bus_rw, 1);
        chk("f_addr",  bus_f.o_bus_address, 32'h2000_0000);
        chk("f_wdata", bus_f.o_bus_wdata, 32'hCAFE_BABE);
      end

      @(posedge clk);
      if (rst) begin
        m_active = 0; m_rel = 0; m_last = 0; m_age = 0;
        m_addr = '0; m_wdata = '0; m_rw = 1'b0;
      end else if (m_active) begin
        if (fin) begin m_active = 0; m_rel = 1; end
        else m_age++;
      end else if (m_rel) begin
        m_rel = 0;
      end else if (bus_a.i_ibus_request || bus_a.i_dbus_request) begin
        if (bus_a.i_ibus_request && bus_a.i_dbus_request) begin
          m_who = !m_last;
          if (m_who) n_tie_d++; else n_tie_i++;
        end else begin
          m_who = bus_a.i_dbus_request;
        end
        m_last   = m_who;
        m_addr   = m_who ? bus_a.i_dbus_address : bus_a.i_ibus_address;
        m_rw     = m_who ? bus_a.i_dbus_rw : 1'b0;
        m_wdata  = m_who ? bus_a.i_dbus_wdata : 32'h0;
        m_active = 1;
        m_age    = 0;
      end

      #1;
      rst = m_active && ($urandom_range(0, 99) == 0);
      bus_a.i_bus_ready = ($urandom_range(0, 3) == 0);
      bus_a.i_bus_rdata = $urandom;
      if (e_ir) begin
        bus_a.i_ibus_request = $urandom_range(0, 1) != 0;
        bus_a.i_ibus_address = $urandom;
      end else if (bus_a.i_ibus_request) begin
        if ($urandom_range(0, 59) == 0) bus_a.i_ibus_request = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus_a.i_ibus_request = 1'b1;
        bus_a.i_ibus_address = $urandom;
      end
      if (e_dr) begin
        bus_a.i_dbus_request = $urandom_range(0, 1) != 0;
        bus_a.i_dbus_address = $urandom;
        bus_a.i_dbus_wdata   = $urandom;
        bus_a.i_dbus_rw      = $urandom_range(0, 1) != 0;
      end else if (bus_a.i_dbus_request) begin
        if ($urandom_range(0, 59) == 0) bus_a.i_dbus_request = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus_a.i_dbus_request = 1'b1;
        bus_a.i_dbus_address = $urandom;
        bus_a.i_dbus_wdata   = $urandom;
        bus_a.i_dbus_rw      = $urandom_range(0, 1) != 0;
      end
    end

    chk("cov_timeout", n_tmo > 0, 1);
    chk("cov_abort",   n_abort > 0, 1);
    chk("cov_tie_i",   n_tie_i > 0, 1);
    chk("cov_tie_d",   n_tie_d > 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
